// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state encodings and constants for the SRAM controller
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_RD = 2'd1,
    ST_D_ACC  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int SRAM_AW_DEFAULT = 20;

  localparam logic STALL      = 1'b1;
  localparam logic NO_STALL   = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  localparam logic [3:0] BE_ALL  = 4'b0000;
  localparam logic [3:0] BE_NONE = 4'b1111;

  function automatic logic full_word(input logic [3:0] sel);
    return sel == 4'b1111;
  endfunction

endpackage

// File: rtl/sram_wmerge.sv
// rtl/sram_wmerge.sv - byte-lane merge of a new store word into an old SRAM word
module sram_wmerge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (sel_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - shared fetch/data SRAM controller; SRAM_BYTE_WRITE_EN selects byte-enable writes over RMW
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int SRAM_AW = SRAM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_inst,
  input  logic               mem_ce,
  input  logic               mem_we,
  input  logic [31:0]        mem_addr,
  input  logic [3:0]         mem_sel,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               stallreq_mem,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [31:0]        sram_dq_i,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  state_t      state_q, state_d;
  logic [31:0] rdata_q;
  logic        need_rmw;
  logic [3:0]  store_be_n;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[31:SRAM_AW+2], if_addr[1:0],
                              mem_addr[31:SRAM_AW+2], mem_addr[1:0]};

`ifdef SRAM_BYTE_WRITE_EN
  assign need_rmw   = 1'b0;
  assign store_be_n = ~mem_sel;
  assign sram_dq_o  = mem_wdata;
`else
  logic [31:0] old_q;

  // Partial stores fetch the old word first; full-word stores skip the read.
  assign need_rmw   = mem_we && !full_word(mem_sel);
  assign store_be_n = BE_ALL;

  sram_wmerge u_wmerge (
    .old_i    (old_q),
    .new_i    (mem_wdata),
    .sel_i    (mem_sel),
    .merged_o (sram_dq_o)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      old_q <= 32'h0;
    end else if (state_q == ST_RMW_RD) begin
      old_q <= sram_dq_i;
    end
  end
`endif

  assign sram_ce_n = rst;
  assign mem_rdata = rdata_q;

  always_comb begin
    state_d      = state_q;
    sram_addr    = if_addr[SRAM_AW+1:2];
    sram_oe_n    = 1'b0;
    sram_we_n    = 1'b1;
    sram_dq_oe   = 1'b0;
    sram_be_n    = BE_ALL;
    if_inst      = 32'h0;
    stallreq_mem = NO_STALL;

    case (state_q)
      ST_IDLE: begin
        if (mem_ce) begin
          stallreq_mem = STALL;
          sram_addr    = mem_addr[SRAM_AW+1:2];
          if (mem_we && !need_rmw) begin
            sram_oe_n  = 1'b1;
            sram_dq_oe = 1'b1;
            sram_be_n  = store_be_n;
          end
          state_d = need_rmw ? ST_RMW_RD : ST_D_ACC;
        end else begin
          if_inst = sram_dq_i;
        end
      end
      ST_RMW_RD: begin
        stallreq_mem = STALL;
        sram_addr    = mem_addr[SRAM_AW+1:2];
        state_d      = ST_D_ACC;
      end
      ST_D_ACC: begin
        stallreq_mem = STALL;
        sram_addr    = mem_addr[SRAM_AW+1:2];
        if (mem_we) begin
          sram_oe_n  = 1'b1;
          sram_dq_oe = 1'b1;
          sram_we_n  = 1'b0;
          sram_be_n  = store_be_n;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset overrides everything, including a store already in D_ACC.
    if (rst == RST_ENABLE) begin
      state_d      = ST_IDLE;
      sram_oe_n    = 1'b1;
      sram_we_n    = 1'b1;
      sram_dq_oe   = 1'b0;
      sram_be_n    = BE_NONE;
      if_inst      = 32'h0;
      stallreq_mem = NO_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_D_ACC && !mem_we) rdata_q <= sram_dq_i;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed self-checking bench for sram_ctrl with a behavioural SRAM
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stallreq_mem;
  logic [19:0] sram_addr;
  logic [31:0] sram_dq_i;
  logic [31:0] sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .if_addr      (if_addr),
    .if_inst      (if_inst),
    .mem_ce       (mem_ce),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_sel      (mem_sel),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .stallreq_mem (stallreq_mem),
    .sram_addr    (sram_addr),
    .sram_dq_i    (sram_dq_i),
    .sram_dq_o    (sram_dq_o),
    .sram_dq_oe   (sram_dq_oe),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_be_n    (sram_be_n)
  );

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n && !sram_dq_oe) ? mem[sram_addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      for (int i = 0; i < 4; i++) begin
        if (!sram_be_n[i]) mem[sram_addr[9:0]][8*i +: 8] <= sram_dq_o[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one data access; reports stall cycles, we_n pulses and DONE-cycle observations.
  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, output int stalls, output int we_pulses,
                        output logic [31:0] we_addr, output logic [3:0] we_be,
                        output logic [31:0] done_rdata, output logic [31:0] done_inst);
    bit done;
    stalls = 0; we_pulses = 0; we_addr = '1; we_be = '1; done_rdata = '1; done_inst = '1;
    done = 0;
    @(posedge clk); #1;
    mem_ce = 1'b1; mem_we = we; mem_addr = addr; mem_sel = sel; mem_wdata = wdata;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (stallreq_mem) begin
        stalls++;
        if (!sram_we_n) begin
          we_pulses++;
          we_addr = {12'h0, sram_addr};
          we_be = sram_be_n;
        end
      end else begin
        done_rdata = mem_rdata;
        done_inst = if_inst;
        done = 1;
      end
    end
    mem_ce = 1'b0; mem_we = 1'b0;
    check("access_done_reached", {31'h0, done}, 32'h1);
  endtask

  int          st, wp;
  logic [31:0] wa, rd, di;
  logic [3:0]  wb;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4]   = 32'h2401_0005;
    mem[64]  = 32'hDEAD_BEEF;
    mem[130] = 32'hAABB_CCDD;
    mem[200] = 32'h5566_7788;

    rst = 1'b1; if_addr = 32'h0; mem_ce = 1'b0; mem_we = 1'b0;
    mem_addr = 32'h0; mem_sel = 4'h0; mem_wdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'h0, stallreq_mem}, 32'h0);
    check("rst_we_n", {31'h0, sram_we_n}, 32'h1);
    check("rst_ce_n", {31'h0, sram_ce_n}, 32'h1);
    check("rst_oe_n", {31'h0, sram_oe_n}, 32'h1);
    check("rst_be_n", {28'h0, sram_be_n}, 32'hF);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    if_addr = 32'h0000_0010;
    @(negedge clk);
    check("fetch_inst", if_inst, 32'h2401_0005);
    check("fetch_addr", {12'h0, sram_addr}, 32'd4);
    check("fetch_ce_n", {31'h0, sram_ce_n}, 32'h0);
    check("fetch_stall", {31'h0, stallreq_mem}, 32'h0);
    check("fetch_be_n", {28'h0, sram_be_n}, 32'h0);

    access(1'b0, 32'h0000_0100, 4'hF, 32'h0, st, wp, wa, wb, rd, di);
    check("load_stalls", st, 32'd2);
    check("load_we_pulses", wp, 32'd0);
    check("load_rdata", rd, 32'hDEAD_BEEF);
    check("load_done_inst", di, 32'h0);

    access(1'b1, 32'h0000_0200, 4'hF, 32'h1234_5678, st, wp, wa, wb, rd, di);
    check("fstore_stalls", st, 32'd2);
    check("fstore_we_pulses", wp, 32'd1);
    check("fstore_addr", wa, 32'd128);
    check("fstore_mem", mem[128], 32'h1234_5678);
    access(1'b0, 32'h0000_0200, 4'hF, 32'h0, st, wp, wa, wb, rd, di);
    check("fstore_readback", rd, 32'h1234_5678);

    access(1'b1, 32'h0000_0208, 4'b0010, 32'h0000_EE00, st, wp, wa, wb, rd, di);
`ifdef SRAM_BYTE_WRITE_EN
    check("bstore_stalls", st, 32'd2);
    check("bstore_be_n", {28'h0, wb}, 32'hD);
`else
    check("bstore_stalls", st, 32'd3);
    check("bstore_be_n", {28'h0, wb}, 32'h0);
`endif
    check("bstore_we_pulses", wp, 32'd1);
    check("bstore_addr", wa, 32'd130);
    check("bstore_mem", mem[130], 32'hAABB_EEDD);

    access(1'b0, 32'hFFC0_0103, 4'hF, 32'h0, st, wp, wa, wb, rd, di);
    check("hiaddr_rdata", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    check("rdata_hold", mem_rdata, 32'hDEAD_BEEF);
    check("idle_inst", if_inst, 32'h2401_0005);

    @(posedge clk); #1;
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0320; mem_sel = 4'hF; mem_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("abort_req_stall", {31'h0, stallreq_mem}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_we_n", {31'h0, sram_we_n}, 32'h1);
    check("abort_stall", {31'h0, stallreq_mem}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check("abort_idle_stall", {31'h0, stallreq_mem}, 32'h0);
    check("abort_idle_oe_n", {31'h0, sram_oe_n}, 32'h0);
    check("abort_idle_inst", if_inst, 32'h2401_0005);
    check("abort_mem", mem[200], 32'h5566_7788);
    check("abort_rdata_clr", mem_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
